// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants for the stopwatch datapath: field widths, per-field
// rollover limits and the default clock / time-base frequencies.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    localparam int DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int DEF_TICK_HZ     = 100;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// -----------------------------------------------------------------------------
// stopwatch_tick_gen
// Divides clk by DIV to produce the centisecond time base.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   i_run    in   level; 1 = count, 0 = hold (sub-tick phase is kept)
//   i_clear  in   level; 1 = zero the divider (priority over run)
//   o_tick   out  registered one-cycle pulse, high the cycle after a wrap
//   o_wrap   out  combinational strobe, high in the cycle whose closing edge
//                 wraps the divider; the digit counters advance on that edge
// -----------------------------------------------------------------------------
module stopwatch_tick_gen
    import stopwatch_pkg::*;
#(
    parameter int DIV = DEF_CLK_FREQ_HZ / DEF_TICK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick,
    output logic o_wrap
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    assign o_wrap = i_run && !i_clear && (tick_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            tick_cnt <= '0;
            o_tick   <= 1'b0;
        end else begin
            o_tick <= o_wrap;
            // Holding (i_run=0) keeps tick_cnt so pause/resume loses no phase.
            if (i_run) begin
                tick_cnt <= o_wrap ? '0 : tick_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_dp.sv
// -----------------------------------------------------------------------------
// stopwatch_dp
// Stopwatch datapath: 100 Hz time base plus cascaded centisecond / second /
// minute / hour counters driven by the run/clear levels of the control FSM.
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency
//   TICK_HZ      time-base rate; CLK_FREQ_HZ/TICK_HZ must be an integer >= 2
//
// Ports:
//   clk      in   system clock (only clock)
//   reset    in   synchronous, active-high reset (priority over clear/run)
//   i_run    in   level; 1 = count, 0 = hold
//   i_clear  in   level; 1 = zero everything (priority over run)
//   i_lap    in   level; only with STOPWATCH_LAP_EN defined. Rising edge
//                 captures the time; while high the outputs show the capture
//   o_msec   out  centiseconds 0..99
//   o_sec    out  seconds 0..59
//   o_min    out  minutes 0..59
//   o_hour   out  hours 0..23
//   o_tick   out  registered one-cycle pulse per time-base tick
//
// Build option: define STOPWATCH_LAP_EN to add the lap-hold display feature.
// -----------------------------------------------------------------------------
module stopwatch_dp
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int TICK_HZ     = DEF_TICK_HZ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic              i_lap,
`endif
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    logic              adv;
    logic [MSEC_W-1:0] msec_q;
    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q;
    logic [HOUR_W-1:0] hour_q;

    stopwatch_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .i_run   (i_run),
        .i_clear (i_clear),
        .o_tick  (o_tick),
        .o_wrap  (adv)
    );

    // Carry chain: each field only moves when every lower field wraps, so the
    // whole time changes on the same edge that raises o_tick.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (adv) begin
            if (msec_q == MSEC_MAX) begin
                msec_q <= '0;
                if (sec_q == SEC_MAX) begin
                    sec_q <= '0;
                    if (min_q == MIN_MAX) begin
                        min_q  <= '0;
                        hour_q <= (hour_q == HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
                    end else begin
                        min_q <= min_q + MIN_W'(1);
                    end
                end else begin
                    sec_q <= sec_q + SEC_W'(1);
                end
            end else begin
                msec_q <= msec_q + MSEC_W'(1);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // lap_active is i_lap delayed one edge: it marks the rising edge for the
    // capture and selects the frozen view from the following cycle on.
    logic              lap_active;
    logic [MSEC_W-1:0] lap_msec;
    logic [SEC_W-1:0]  lap_sec;
    logic [MIN_W-1:0]  lap_min;
    logic [HOUR_W-1:0] lap_hour;

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_active <= 1'b0;
            lap_msec   <= '0;
            lap_sec    <= '0;
            lap_min    <= '0;
            lap_hour   <= '0;
        end else begin
            lap_active <= i_lap;
            if (i_clear) begin
                lap_msec <= '0;
                lap_sec  <= '0;
                lap_min  <= '0;
                lap_hour <= '0;
            end else if (i_lap && !lap_active) begin
                // Capture the value on display before this edge.
                lap_msec <= msec_q;
                lap_sec  <= sec_q;
                lap_min  <= min_q;
                lap_hour <= hour_q;
            end
        end
    end

    assign o_msec = lap_active ? lap_msec : msec_q;
    assign o_sec  = lap_active ? lap_sec  : sec_q;
    assign o_min  = lap_active ? lap_min  : min_q;
    assign o_hour = lap_active ? lap_hour : hour_q;
`else
    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
`endif

endmodule

// File: tb/tb_stopwatch_dp.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_dp
// Self-checking bench for stopwatch_dp with CLK_FREQ_HZ=1000, TICK_HZ=100
// (divider of 10). Every cycle the expected {tick,hour,min,sec,msec} from a
// behavioural model is queued when inputs are driven and compared after the
// following rising edge; directed checks cover the listed scenarios.
// Define STOPWATCH_LAP_EN to also exercise the lap-hold feature.
// -----------------------------------------------------------------------------
module tb_stopwatch_dp;

    localparam int DIV = 10;
    localparam int VW  = 25;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_run = 1'b0;
    logic i_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic i_lap = 1'b0;
`endif
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    always #5 clk = ~clk;

    stopwatch_dp #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_run   (i_run),
        .i_clear (i_clear),
`ifdef STOPWATCH_LAP_EN
        .i_lap   (i_lap),
`endif
        .o_msec  (o_msec),
        .o_sec   (o_sec),
        .o_min   (o_min),
        .o_hour  (o_hour),
        .o_tick  (o_tick)
    );

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_cnt = 0, m_ms = 0, m_s = 0, m_m = 0, m_h = 0, m_tick = 0;
    int l_ms = 0, l_s = 0, l_m = 0, l_h = 0, l_act = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] pack(input int t, input int h, input int m,
                                           input int s, input int ms);
        return {1'(t), 5'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    function automatic logic [VW-1:0] expected_view();
        if (l_act != 0) return pack(m_tick, l_h, l_m, l_s, l_ms);
        return pack(m_tick, m_h, m_m, m_s, m_ms);
    endfunction

    // advance the model by one edge, using pre-edge state
    task automatic model_edge(input logic rst, input logic run, input logic clr, input logic lap);
        if (rst) begin
            m_cnt = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0; m_tick = 0;
            l_ms = 0; l_s = 0; l_m = 0; l_h = 0; l_act = 0;
        end else begin
            if (LAP_EN) begin
                if (clr) begin
                    l_ms = 0; l_s = 0; l_m = 0; l_h = 0;
                end else if (lap && l_act == 0) begin
                    l_ms = m_ms; l_s = m_s; l_m = m_m; l_h = m_h;
                end
                l_act = lap ? 1 : 0;
            end
            if (clr) begin
                m_cnt = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0; m_tick = 0;
            end else if (run) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_tick = 1;
                    m_ms = m_ms + 1;
                    if (m_ms == 100) begin
                        m_ms = 0; m_s = m_s + 1;
                        if (m_s == 60) begin
                            m_s = 0; m_m = m_m + 1;
                            if (m_m == 60) begin
                                m_m = 0; m_h = (m_h + 1) % 24;
                            end
                        end
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                    m_tick = 0;
                end
            end else begin
                m_tick = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic run, input logic clr, input logic lap);
        logic [VW-1:0] got;
        logic [VW-1:0] exp;
        @(negedge clk);
        reset   = rst;
        i_run   = run;
        i_clear = clr;
`ifdef STOPWATCH_LAP_EN
        i_lap   = lap;
`endif
        model_edge(rst, run, clr, lap);
        exp_q.push_back(expected_view());
        @(posedge clk);
        #1;
        got = {o_tick, o_hour, o_min, o_sec, o_msec};
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("cycle", 32'(got), 32'(exp));
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Load the live counters directly (reaching 23:59:59 by counting would
    // take millions of cycles). Done during a hold cycle so nothing else moves.
    task automatic preload(input int h, input int m, input int s, input int ms);
        force dut.hour_q = 5'(h);
        force dut.min_q  = 6'(m);
        force dut.sec_q  = 6'(s);
        force dut.msec_q = 7'(ms);
        m_h = h; m_m = m; m_s = s; m_ms = ms;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        release dut.hour_q;
        release dut.min_q;
        release dut.sec_q;
        release dut.msec_q;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_ticks;
        int last;

        // 1. reset then 100 run cycles
        do_reset();
        do_reset();
        check("reset_msec", 32'(o_msec), 32'd0);
        check("reset_sec", 32'(o_sec), 32'd0);
        check("reset_min", 32'(o_min), 32'd0);
        check("reset_hour", 32'(o_hour), 32'd0);
        check("reset_tick", 32'(o_tick), 32'd0);
        n_ticks = 0;
        last = -1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (o_tick) begin
                if (last < 0) check("first_tick_cycle", 32'(i), 32'd9);
                else          check("tick_gap", 32'(i - last), 32'd10);
                last = i;
                n_ticks++;
            end
        end
        check("tick_count_100", 32'(n_ticks), 32'd10);
        check("msec_after_100", 32'(o_msec), 32'd10);

        // 2. pause / resume keeps sub-tick phase
        do_reset();
        run_n(35);
        check("msec_before_hold", 32'(o_msec), 32'd3);
        n_ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (o_tick) n_ticks++;
            if (i == 49) check("msec_in_hold", 32'(o_msec), 32'd3);
        end
        check("ticks_in_hold", 32'(n_ticks), 32'd0);
        run_n(4);
        check("msec_resume_4", 32'(o_msec), 32'd3);
        run_n(1);
        check("msec_resume_5", 32'(o_msec), 32'd4);
        check("tick_resume_5", 32'(o_tick), 32'd1);

        // 3. carry into minutes and full-day wrap
        do_reset();
        preload(0, 0, 59, 99);
        run_n(9);
        check("pre_carry_msec", 32'(o_msec), 32'd99);
        run_n(1);
        check("carry_time", 32'({o_hour, o_min, o_sec, o_msec}), 32'({5'd0, 6'd1, 6'd0, 7'd0}));
        preload(23, 59, 59, 99);
        run_n(10);
        check("day_wrap_time", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        check("day_wrap_tick", 32'(o_tick), 32'd1);

        // 4. clear has priority over run
        do_reset();
        run_n(1230);
        check("at_1_23_sec", 32'(o_sec), 32'd1);
        check("at_1_23_msec", 32'(o_msec), 32'd23);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("clear_time", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        check("clear_tick", 32'(o_tick), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("clear_held", 32'(o_msec), 32'd0);
        run_n(10);
        check("after_clear_msec", 32'(o_msec), 32'd1);

        // 5. reset mid-count restarts the divider
        do_reset();
        run_n(17);
        check("pre_reset_msec", 32'(o_msec), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_reset_time", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        n_ticks = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (o_tick) n_ticks++;
        end
        check("no_early_tick", 32'(n_ticks), 32'd0);
        run_n(1);
        check("tick_after_reset", 32'(o_tick), 32'd1);
        check("msec_after_reset", 32'(o_msec), 32'd1);

`ifdef STOPWATCH_LAP_EN
        // 6. lap hold
        do_reset();
        run_n(50);
        check("lap_start_msec", 32'(o_msec), 32'd5);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            check("lap_frozen", 32'({o_hour, o_min, o_sec, o_msec}), 32'd5);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap_release", 32'(o_msec), 32'd9);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("lap_cleared", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("lap_cleared_held", 32'(o_msec), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap_live_again", 32'(o_msec), 32'd2);
`endif

        // random run / hold / clear mix, checked by the scoreboard
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 LAP_EN && ($urandom_range(0, 7) == 0));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_dp.md
Name: stopwatch_dp

Overview:
Datapath half of the stopwatch. It consumes the run/clear level commands produced by the stopwatch control FSM. It divides the system clock into a 100 Hz time base and keeps a cascaded centisecond/second/minute/hour count for the display/FND driver. It is purely sequential and has no button handling; debouncing and the FSM live upstream.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
TICK_HZ, 100, time-base rate (one tick = one centisecond). DIV = CLK_FREQ_HZ/TICK_HZ; must be an integer >= 2.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
i_run  input  1  level; 1 = count, 0 = hold.
i_clear  input  1  level; 1 = force all counts to zero.
o_msec  output  7  centiseconds, 0..99.
o_sec  output  6  seconds, 0..59.
o_min  output  6  minutes, 0..59.
o_hour  output  5  hours, 0..23.
o_tick  output  1  one-cycle pulse on each time-base tick (registered).

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high, sampled on the rising edge of clk. It zeroes the tick counter, o_msec, o_sec, o_min, o_hour and o_tick.
- Tick counter tick_cnt, width $clog2(DIV):
  - If i_run=1 and i_clear=0, it increments every cycle and wraps DIV-1 -> 0.
  - If i_run=0, it holds its value, so a pause/resume loses no sub-tick time.
- o_tick is registered. It is 1 for exactly the cycle after the edge where tick_cnt wrapped DIV-1 -> 0 with i_run=1. It is 0 otherwise.
- Time counters advance on the same clock edge as the tick_cnt wrap, so they change together with the o_tick rise.
  - msec: 0..99, 99 -> 0 with carry.
  - On carry, sec: 0..59, 59 -> 0 with carry.
  - On carry, min: 0..59, 59 -> 0 with carry.
  - On carry, hour: 0..23, 23 -> 0 (silent rollover, no overflow flag).
  - Full wrap: 23:59:59.99 -> 00:00:00.00 on one tick.
  - No counter ever holds an out-of-range value.
- Clear:
  - When i_clear=1 at an edge, tick_cnt and all time outputs become 0 and o_tick becomes 0.
  - Clear has priority over run (i_run=1 and i_clear=1 gives clear).
  - Clear held for multiple cycles keeps everything at 0.
- Hold: when i_run=0 and i_clear=0, all state holds and o_tick=0.
- Reset has priority over clear and run. Reset mid-count returns everything to 0 on that edge. Counting restarts from tick_cnt=0 once reset is released and i_run=1.
- Latency:
  - From i_run rising with tick_cnt=0, the first o_msec increment is DIV edges later.
  - Clear takes effect one edge after i_clear is sampled high.

Optional Feature:
Macro STOPWATCH_LAP_EN.
- With the macro defined:
  - Adds port i_lap (input, 1 bit, level).
  - On the edge where i_lap goes 0 -> 1, the current time values are captured into lap registers. While i_lap=1, o_msec/o_sec/o_min/o_hour show the lap registers; internal counting continues unaffected.
  - When i_lap returns to 0, the outputs show live values on the next cycle.
  - i_clear=1 or reset zeroes the lap registers and the frozen display shows 0.
  - o_tick is never frozen.
- Without the macro: no i_lap port and no lap registers; outputs are always live.

Decomposition:
- Shared package/header stopwatch_pkg holds:
  - width localparams: MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5;
  - limit constants: MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - the default CLK_FREQ_HZ and TICK_HZ.
- One natural sub-module: stopwatch_tick_gen (parameter DIV; ports clk, reset, i_run, i_clear, o_tick).
- The four digit counters stay inline in stopwatch_dp as a carry chain.

Test Plan:
All tests use CLK_FREQ_HZ=1000 and TICK_HZ=100, giving DIV=10.
1. Reset, then i_run=1 for 100 cycles -> exactly 10 o_tick pulses, spaced 10 cycles apart; o_msec=10 at end.
2. Run 35 cycles, i_run=0 for 50 cycles, then i_run=1 for 5 cycles -> o_msec=3 during the hold, o_msec=4 exactly 5 cycles after resume, no o_tick during the hold.
3. Preload by running to 00:00:59.99, then one more tick -> 00:01:00.00 on that single edge. Run to 23:59:59.99, then one tick -> 00:00:00.00.
4. While counting at 00:00:01.23, assert i_run=1 and i_clear=1 together for 1 cycle -> all outputs 0 on the next edge. With i_clear=0, counting restarts and o_msec=1 after 10 cycles.
5. Assert reset mid-count with tick_cnt=7 -> all outputs 0 next edge. After release with i_run=1, the first tick comes 10 cycles later, not 3.
6. (STOPWATCH_LAP_EN) At o_msec=5, i_lap=1 for 40 cycles -> outputs stay at 0.05 throughout. On i_lap=0, outputs show 0.09 on the next cycle.
